uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, runtime-configurable UART transmitter. It generalises the fixed-rate, 8N1 serial stimulus used to drive the `udm` debug bridge's `rx_i` line. It adds:
- a parametrised TX FIFO,
- a runtime bit-period divider,
- 5–8 data bits, none/even/odd parity and 1 or 2 stop bits.

It sits beside `udm` in `sigma`. It serves both as the on-chip host-link transmitter and as a synthesizable loopback stimulus for FPGA self-test.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: TX FIFO entries; must be a power of two, ≥2.
- `DIV_W`, 32: width of the bit-period divider.

Ports:
- `clk_i`  in  1  system clock.
- `arst_i`  in  1  reset, asynchronous, active-high.
- `div_i`  in  DIV_W  bit period in `clk_i` cycles; 0 and 1 are treated as 1.
- `data_bits_i`  in  2  data bit count: 0→5, 1→6, 2→7, 3→8.
- `parity_i`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none (reserved).
- `stop2_i`  in  1  stop bits: 1 selects two stop bits, 0 selects one.
- `tx_req_i`  in  1  write request.
- `tx_data_i`  in  8  write data; bits above the selected width are ignored.
- `tx_ack_o`  out  1  `!full`; a write is accepted on an edge where `tx_req_i && tx_ack_o`.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `busy_o`  out  1  a frame is being shifted out.
- `done_o`  out  1  one-cycle pulse at the end of each frame.
- `tx_o`  out  1  serial line; idles high.

## Operation
- Reset values: `tx_o`=1, `busy_o`=0, `done_o`=0, `level_o`=0, `tx_ack_o`=1. The FIFO is emptied and the FSM returns to IDLE.
- FSM states are IDLE → START → DATA → PARITY → STOP → IDLE.
- **IDLE:** if the FIFO is non-empty, pop the head word into the shift register. In the same cycle, latch `div_i`, `data_bits_i`, `parity_i` and `stop2_i`, then go to START. Configuration changes mid-frame have no effect until the next pop.
- **START:** `tx_o`=0 for one bit period.
- **DATA:** send N data bits, LSB first, one bit period each.
- **PARITY:** entered only when parity is enabled. Even parity sends the XOR of the N transmitted bits; odd parity sends its inverse.
- **STOP:** `tx_o`=1 for 1 or 2 bit periods. On the last cycle of the last stop bit:
  - assert `done_o`;
  - if the FIFO is non-empty, pop and go directly to START, so frames run back-to-back with no idle gap;
  - otherwise go to IDLE.
- **Baud counter:** counts 0 … div−1 within each bit and advances the bit at div−1.
- **Bit counter:** counts transmitted data bits and wraps at N.
- **FIFO:**
  - A write and a pop in the same cycle leave `level_o` unchanged.
  - When full, `tx_ack_o`=0 and writes are not accepted, even if a pop happens in the same cycle.
  - A pop never occurs while the FIFO is empty.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Reset during a frame:** `tx_o` goes to 1 immediately (asynchronously) and any partial frame is discarded.

## Timing
- **Write to line:** a write accepted at edge k into an empty FIFO with the FSM idle makes `tx_o` low after edge k+2 (FIFO write, then pop/START).
- **Frame length:** (1 + N + P + S) × div cycles, where P is 1 if parity is enabled, else 0, and S is the stop-bit count.
- **`done_o`:** high for exactly one cycle, which is the final cycle of the last stop bit.
- **`busy_o`:** 1 from START through STOP inclusive, including across back-to-back frames.
- **`level_o`:** updates one cycle after the accepting edge. It drops by one on the pop edge.
- **`tx_ack_o`:** combinational from the FIFO full flag.
- All outputs except `tx_ack_o` are registered.

## Structure
- Package `uart_pkg` holds:
  - `parity_e` (NONE, EVEN, ODD);
  - `tx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - the data-bits decode function (2'b00→5 … 2'b11→8);
  - localparams for the standard divider values (115200/19200/9600/4800/2400 at 100 MHz).
- Sub-module `uart_fifo`: a synchronous FIFO with `FIFO_DEPTH`/`W` parameters, push/pop/full/empty/level, and the same clock and async reset. It is reused later by the RX path.
- Top-level RTL contains the FSM, baud counter, bit counter, shift register and parity accumulator.

## Test plan
- div=4, 8N1, write 0x55 → `tx_o` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `done_o` pulses on cycle 40 of the frame; `busy_o` then drops to 0.
- div=3, 7 data bits, even parity, 2 stop bits, write 0xC1 → data 1,0,0,0,0,0,1, parity 0, two stop bits. Frame is 33 cycles; bit 7 is not sent.
- div=2, 5 data bits, odd parity, write 0x1F → data 1,1,1,1,1, parity 0, frame 16 cycles.
- div=100, 8N1, FIFO_DEPTH=16, 20 consecutive requests → 17 accepted (one popped at once), `tx_ack_o`=0 and `level_o`=16. The 17 frames are sent back-to-back with no idle cycles, and `done_o` pulses 17 times.
- During the 4th data bit, change `div_i` from 4 to 8 and `parity_i` to even → the current frame completes at div=4 with no parity bit. The next queued frame uses div=8 with even parity.
- Assert `arst_i` mid-frame with `level_o`=5 → `tx_o`=1 in the same cycle. After release, `level_o`=0, `busy_o`=0 and the line stays idle high.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame-format decode helpers and standard baud divisors.
package uart_pkg;
   typedef enum logic [1:0] {NONE, EVEN, ODD} parity_e;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
   localparam int unsigned DIV_115200 = 868;
   localparam int unsigned DIV_19200 = 5208;
   localparam int unsigned DIV_9600 = 10417;
   localparam int unsigned DIV_4800 = 20833;
   localparam int unsigned DIV_2400 = 41667;
   function automatic logic [3:0] data_bits(input logic [1:0] sel);
      return 4'd5 + {2'b00, sel};
   endfunction
   function automatic parity_e parity_decode(input logic [1:0] sel);
      return sel == 2'b01 ? EVEN : sel == 2'b10 ? ODD : NONE;
   endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with occupancy count, shared by the UART TX and RX paths.
module uart_fifo #(
   parameter int DEPTH = 16,
   parameter int W = 8
) (
   input  logic                     clk_i,
   input  logic                     arst_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wr_data,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign rd_data = mem[rp];
   always_ff @(posedge clk_i)
      if (do_push) mem[wp] <= wr_data;
   always_ff @(posedge clk_i or posedge arst_i)
      if (arst_i) begin
         wp <= '0;
         rp <= '0;
         level <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with runtime divider, 5-8 data bits, parity and 1/2 stop bits.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W = 32
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic [DIV_W-1:0]              div_i,
   input  logic [1:0]                    data_bits_i,
   input  logic [1:0]                    parity_i,
   input  logic                          stop2_i,
   input  logic                          tx_req_i,
   input  logic [7:0]                    tx_data_i,
   output logic                          tx_ack_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          tx_o
);
   tx_state_e state, state_n;
   parity_e par_q;
   logic [DIV_W-1:0] div_q, baud;
   logic [3:0] nbits_q, bit_cnt;
   logic [7:0] sh, head;
   logic stop2_q, acc, full, empty, pop, tick, last_data, last_stop;
   logic tx_n, busy_n, done_n;

   uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk_i(clk_i), .arst_i(arst_i), .push(tx_req_i), .pop(pop), .wr_data(tx_data_i),
      .rd_data(head), .full(full), .empty(empty), .level(level_o)
   );

   assign tx_ack_o = !full;
   assign tick = baud == div_q - DIV_W'(1);
   assign last_data = bit_cnt == nbits_q - 4'd1;
   assign last_stop = bit_cnt == {3'd0, stop2_q};
   // popping at the end of the last stop bit chains frames with no idle gap
   assign pop = !empty && (state == IDLE || (state == STOP && tick && last_stop));

   always_ff @(posedge clk_i or posedge arst_i)
      if (arst_i) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = empty ? IDLE : START;
         START:   if (tick) state_n = DATA;
         DATA:    if (tick && last_data) state_n = par_q == NONE ? STOP : PARITY;
         PARITY:  if (tick) state_n = STOP;
         STOP:    if (tick && last_stop) state_n = empty ? IDLE : START;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      tx_n = state == START ? 1'b0 : state == DATA ? sh[0] : state == PARITY ? acc ^ (par_q == ODD) : 1'b1;
      busy_n = state != IDLE;
      done_n = state == STOP && tick && last_stop;
   end

   always_ff @(posedge clk_i or posedge arst_i)
      if (arst_i) begin
         tx_o <= 1'b1;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         tx_o <= tx_n;
         busy_o <= busy_n;
         done_o <= done_n;
      end

   // frame format is captured on pop so mid-frame config changes only affect later frames
   always_ff @(posedge clk_i or posedge arst_i)
      if (arst_i) begin
         div_q <= DIV_W'(1);
         nbits_q <= 4'd8;
         par_q <= NONE;
         stop2_q <= 1'b0;
         sh <= '0;
         acc <= 1'b0;
         baud <= '0;
         bit_cnt <= '0;
      end else if (pop) begin
         div_q <= div_i > DIV_W'(1) ? div_i : DIV_W'(1);
         nbits_q <= data_bits(data_bits_i);
         par_q <= parity_decode(parity_i);
         stop2_q <= stop2_i;
         sh <= head;
         acc <= 1'b0;
         baud <= '0;
         bit_cnt <= '0;
      end else if (state != IDLE) begin
         baud <= tick ? '0 : baud + DIV_W'(1);
         if (tick) begin
            bit_cnt <= state_n != state ? 4'd0 : bit_cnt + 4'd1;
            if (state == DATA) begin
               sh <= sh >> 1;
               acc <= acc ^ sh[0];
            end
         end
      end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for the buffered UART transmitter.
module tb_uart_tx_fifo;
   logic clk = 1'b0, arst = 1'b1;
   logic [31:0] div = 32'd4;
   logic [1:0] dbits = 2'd3, par = 2'd0;
   logic stop2 = 1'b0, req = 1'b0;
   logic [7:0] data = 8'd0;
   logic ack, busy, done, tx;
   logic [4:0] level;
   int errors = 0, checks = 0;
   logic cap_tx [17100];
   logic cap_done [17100];
   logic cap_busy [17100];

   uart_tx_fifo dut (
      .clk_i(clk), .arst_i(arst), .div_i(div), .data_bits_i(dbits), .parity_i(par),
      .stop2_i(stop2), .tx_req_i(req), .tx_data_i(data), .tx_ack_o(ack), .level_o(level),
      .busy_o(busy), .done_o(done), .tx_o(tx)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cfg(input int d, input logic [1:0] b, input logic [1:0] p, input logic s);
      div = d;
      dbits = b;
      par = p;
      stop2 = s;
   endtask

   task automatic push_bytes(input int n, input logic [7:0] base, output int acc);
      acc = 0;
      @(negedge clk);
      req = 1'b1;
      for (int i = 0; i < n; i++) begin
         data = base + 8'(i);
         if (ack === 1'b1) acc++;
         @(negedge clk);
      end
      req = 1'b0;
   endtask

   task automatic wait_start(output int lat);
      lat = -1;
      for (int i = 0; i < 2000; i++) begin
         if (tx === 1'b0) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic capture(input int len);
      for (int i = 0; i < len; i++) begin
         cap_tx[i] = tx;
         cap_done[i] = done;
         cap_busy[i] = busy;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      arst = 1'b1;
      repeat (2) @(negedge clk);
      checks += 5;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      if (ack !== 1'b1) begin errors++; $display("FAIL reset_ack: got %b expected 1", ack); end
      arst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
   endtask

   task automatic test_8n1;
      logic [0:15] exp;
      int lat, acc, bad, nd;
      exp = 16'b0101010101000000;
      cfg(4, 2'd3, 2'd0, 1'b0);
      push_bytes(1, 8'h55, acc);
      wait_start(lat);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL 8n1_latency: got %0d cycles expected 2", lat); end
      capture(44);
      bad = -1;
      nd = 0;
      for (int i = 0; i < 44; i++) begin
         if (i < 40 && bad < 0 && cap_tx[i] !== exp[i/4]) bad = i;
         if (cap_done[i] === 1'b1) nd++;
      end
      checks += 4;
      if (bad >= 0) begin errors++; $display("FAIL 8n1_line: cycle %0d tx=%b expected %b", bad, cap_tx[bad], exp[bad/4]); end
      if (nd != 1 || cap_done[39] !== 1'b1) begin errors++; $display("FAIL 8n1_done: %0d pulses, cycle40=%b expected 1 pulse on cycle 40", nd, cap_done[39]); end
      if (cap_busy[0] !== 1'b1 || cap_busy[39] !== 1'b1 || cap_busy[40] !== 1'b0) begin errors++; $display("FAIL 8n1_busy: got %b%b%b expected 110", cap_busy[0], cap_busy[39], cap_busy[40]); end
      if (cap_tx[40] !== 1'b1 || cap_tx[43] !== 1'b1) begin errors++; $display("FAIL 8n1_idle: got %b%b expected 11", cap_tx[40], cap_tx[43]); end
   endtask

   task automatic test_7e2;
      logic [0:15] exp;
      int lat, acc, bad, nd;
      exp = 16'b0100000101100000;
      cfg(3, 2'd2, 2'b01, 1'b1);
      push_bytes(1, 8'hC1, acc);
      wait_start(lat);
      capture(37);
      bad = -1;
      nd = 0;
      for (int i = 0; i < 37; i++) begin
         if (i < 33 && bad < 0 && cap_tx[i] !== exp[i/3]) bad = i;
         if (cap_done[i] === 1'b1) nd++;
      end
      checks += 3;
      if (bad >= 0) begin errors++; $display("FAIL 7e2_line: cycle %0d tx=%b expected %b", bad, cap_tx[bad], exp[bad/3]); end
      if (nd != 1 || cap_done[32] !== 1'b1) begin errors++; $display("FAIL 7e2_done: %0d pulses, cycle33=%b expected 1 pulse on cycle 33", nd, cap_done[32]); end
      if (cap_busy[32] !== 1'b1 || cap_busy[33] !== 1'b0 || cap_tx[33] !== 1'b1) begin errors++; $display("FAIL 7e2_end: busy=%b%b tx=%b expected busy=10 tx=1", cap_busy[32], cap_busy[33], cap_tx[33]); end
   endtask

   task automatic test_5o1;
      logic [0:15] exp;
      int lat, acc, bad, nd;
      exp = 16'b0111110100000000;
      cfg(2, 2'd0, 2'b10, 1'b0);
      push_bytes(1, 8'h1F, acc);
      wait_start(lat);
      capture(20);
      bad = -1;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < 16 && bad < 0 && cap_tx[i] !== exp[i/2]) bad = i;
         if (cap_done[i] === 1'b1) nd++;
      end
      checks += 3;
      if (bad >= 0) begin errors++; $display("FAIL 5o1_line: cycle %0d tx=%b expected %b", bad, cap_tx[bad], exp[bad/2]); end
      if (nd != 1 || cap_done[15] !== 1'b1) begin errors++; $display("FAIL 5o1_done: %0d pulses, cycle16=%b expected 1 pulse on cycle 16", nd, cap_done[15]); end
      if (cap_busy[16] !== 1'b0 || cap_tx[16] !== 1'b1) begin errors++; $display("FAIL 5o1_end: busy=%b tx=%b expected busy=0 tx=1", cap_busy[16], cap_tx[16]); end
   endtask

   task automatic test_cfg_change;
      logic [0:15] e1, e2;
      int lat, acc, bad, nd;
      e1 = 16'b0111100001000000;
      e2 = 16'b0000010001100000;
      cfg(4, 2'd3, 2'd0, 1'b0);
      push_bytes(2, 8'h0F, acc);
      wait_start(lat);
      fork
         capture(132);
         begin
            repeat (18) @(negedge clk);
            div = 32'd8;
            par = 2'b01;
         end
      join
      bad = -1;
      nd = 0;
      for (int i = 0; i < 132; i++) begin
         if (i < 40 && bad < 0 && cap_tx[i] !== e1[i/4]) bad = i;
         if (i >= 40 && i < 128 && bad < 0 && cap_tx[i] !== e2[(i-40)/8]) bad = i;
         if (cap_done[i] === 1'b1) nd++;
      end
      checks += 3;
      if (bad >= 0) begin errors++; $display("FAIL cfg_line: cycle %0d tx=%b", bad, cap_tx[bad]); end
      if (nd != 2 || cap_done[39] !== 1'b1 || cap_done[127] !== 1'b1) begin errors++; $display("FAIL cfg_done: %0d pulses, cycle40=%b cycle128=%b expected 2 pulses on 40 and 128", nd, cap_done[39], cap_done[127]); end
      if (cap_busy[40] !== 1'b1 || cap_busy[128] !== 1'b0) begin errors++; $display("FAIL cfg_busy: got %b%b expected 10", cap_busy[40], cap_busy[128]); end
   endtask

   task automatic test_back_to_back;
      int acc, lat, nd, bad;
      logic [7:0] got;
      cfg(100, 2'd3, 2'd0, 1'b0);
      fork
         begin
            push_bytes(20, 8'hA0, acc);
            checks += 3;
            if (acc != 17) begin errors++; $display("FAIL b2b_accepted: got %0d expected 17", acc); end
            if (ack !== 1'b0) begin errors++; $display("FAIL b2b_ack: got %b expected 0", ack); end
            if (level !== 5'd16) begin errors++; $display("FAIL b2b_level: got %0d expected 16", level); end
         end
         begin
            wait_start(lat);
            capture(17100);
         end
      join
      checks++;
      if (lat < 0) begin errors++; $display("FAIL b2b_start: got no start bit expected one"); end
      nd = 0;
      bad = -1;
      for (int i = 0; i < 17100; i++) begin
         if (cap_done[i] === 1'b1) nd++;
         if (bad < 0 && i < 17000 && cap_busy[i] !== 1'b1) bad = i;
      end
      checks += 2;
      if (nd != 17 || cap_done[16999] !== 1'b1) begin errors++; $display("FAIL b2b_done: %0d pulses, last=%b expected 17 pulses ending at cycle 17000", nd, cap_done[16999]); end
      if (bad >= 0 || cap_busy[17000] !== 1'b0) begin errors++; $display("FAIL b2b_busy: gap at %0d, after=%b expected no gap then 0", bad, cap_busy[17000]); end
      bad = -1;
      for (int f = 0; f < 17; f++) begin
         got = 8'd0;
         for (int b = 0; b < 8; b++) got[b] = cap_tx[f*1000 + 150 + b*100];
         if (bad < 0 && (got !== 8'hA0 + 8'(f) || cap_tx[f*1000+50] !== 1'b0 || cap_tx[f*1000+950] !== 1'b1)) bad = f;
      end
      checks += 2;
      if (bad >= 0) begin errors++; $display("FAIL b2b_data: frame %0d wrong, expected byte %h", bad, 8'hA0 + 8'(bad)); end
      if (level !== 5'd0 || ack !== 1'b1) begin errors++; $display("FAIL b2b_drain: level=%0d ack=%b expected 0 1", level, ack); end
   endtask

   task automatic test_reset_mid_frame;
      int acc, lat, bad;
      cfg(100, 2'd3, 2'd0, 1'b0);
      push_bytes(6, 8'h00, acc);
      wait_start(lat);
      repeat (250) @(negedge clk);
      checks += 2;
      if (level !== 5'd5) begin errors++; $display("FAIL rst_pre_level: got %0d expected 5", level); end
      if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre_line: tx=%b busy=%b expected 0 1", tx, busy); end
      arst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: tx=%b busy=%b expected 1 0", tx, busy); end
      @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      checks++;
      if (level !== 5'd0 || ack !== 1'b1) begin errors++; $display("FAIL rst_post_fifo: level=%0d ack=%b expected 0 1", level, ack); end
      bad = -1;
      for (int i = 0; i < 300; i++) begin
         if (bad < 0 && (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)) bad = i;
         @(negedge clk);
      end
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL rst_post_idle: activity at cycle %0d expected idle line", bad); end
   endtask

   initial begin
      test_reset;
      test_8n1;
      test_7e2;
      test_5o1;
      test_cfg_change;
      test_back_to_back;
      test_reset_mid_frame;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
